cla_pipe_adder: RTL



---
 rtl/cla_pipe_adder.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// Pipelined carry-lookahead adder/subtractor: one SW-bit slice per stage, LSB first.
// Latency: STAGES cycles from accepted input to out_valid; one result per cycle.
// Backpressure: whole pipeline advances only when !out_valid || out_ready; in_ready mirrors it.
//
// Ports:
//   clk, rst_n           single rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (a, b, sub, c_in)
//   out_valid/out_ready  result handshake (s, c_out, ovf, zero)
// Build option: define CLA_PIPE_SAT_EN to saturate s to the signed limits on overflow.
module cla_pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);

    localparam int SW = WIDTH / STAGES;  // slice width per stage
    localparam int NG = SW / 8;          // 8-bit lookahead groups per slice
    localparam int L  = STAGES - 1;      // index of the last stage

    // Slice adder. Every carry is a flat generate/propagate prefix ending in
    // the slice carry-in, so no carry depends on the carry of another group.
    // Returns {carry_out, sum}.
    function automatic logic [SW:0] cla_slice(
        input logic [SW-1:0] x,
        input logic [SW-1:0] y,
        input logic          ci
    );
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW-1:0] c;
        logic [NG-1:0] gg;
        logic [NG-1:0] pg;
        logic [NG:0]   cg;
        logic          gacc;
        logic          pacc;
        g  = x & y;
        p  = x ^ y;
        c  = '0;
        gg = '0;
        pg = '0;
        cg = '0;
        // group generate / propagate
        for (int j = 0; j < NG; j++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int i = 0; i < 8; i++) begin
                gacc = g[j*8+i] | (p[j*8+i] & gacc);
                pacc = pacc & p[j*8+i];
            end
            gg[j] = gacc;
            pg[j] = pacc;
        end
        // group carry-ins, each a lookahead over groups 0..j-1
        cg[0] = ci;
        for (int j = 0; j < NG; j++) begin
            gacc = 1'b0;
            pacc = 1'b1;
            for (int m = 0; m <= j; m++) begin
                gacc = gg[m] | (pg[m] & gacc);
                pacc = pacc & pg[m];
            end
            cg[j+1] = gacc | (pacc & ci);
        end
        // bit carries inside each group, lookahead from the group carry-in
        for (int j = 0; j < NG; j++) begin
            for (int i = 0; i < 8; i++) begin
                gacc = 1'b0;
                pacc = 1'b1;
                for (int t = 0; t < i; t++) begin
                    gacc = g[j*8+t] | (p[j*8+t] & gacc);
                    pacc = pacc & p[j*8+t];
                end
                c[j*8+i] = gacc | (pacc & cg[j]);
            end
        end
        return {cg[NG], p ^ c};
    endfunction

    // Stage registers: operands still to be added, partial sum, slice carry.
    logic             r_vld [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_s   [STAGES];
    logic             r_c   [STAGES];

    logic [WIDTH-1:0] r_s_out;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    // Stage k inputs and combinational results.
    logic [WIDTH-1:0] w_a_in  [STAGES];
    logic [WIDTH-1:0] w_b_in  [STAGES];
    logic [WIDTH-1:0] w_s_in  [STAGES];
    logic             w_c_in  [STAGES];
    logic [WIDTH-1:0] w_s_nxt [STAGES];
    logic             w_c_nxt [STAGES];

    logic             w_adv;
    logic             w_msb_cin;
    logic             w_ovf;
    logic             w_zero;
    logic [WIDTH-1:0] w_s_fin;

    assign w_adv    = !r_vld[L] || out_ready;
    assign in_ready = w_adv;

    always_comb begin
        logic [SW:0] sum_t;
        sum_t = '0;
        // stage 0 sees the effective operands; subtract is A + ~B + 1
        w_a_in[0] = a;
        w_b_in[0] = sub ? ~b : b;
        w_c_in[0] = sub ? 1'b1 : c_in;
        w_s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            w_a_in[k] = r_a[k-1];
            w_b_in[k] = r_b[k-1];
            w_c_in[k] = r_c[k-1];
            w_s_in[k] = r_s[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            sum_t      = cla_slice(w_a_in[k][k*SW +: SW], w_b_in[k][k*SW +: SW], w_c_in[k]);
            w_s_nxt[k] = w_s_in[k];
            w_s_nxt[k][k*SW +: SW] = sum_t[SW-1:0];
            w_c_nxt[k] = sum_t[SW];
        end
    end

    // Final flags. The carry into the MSB is recovered from the MSB sum bit.
    always_comb begin
        w_msb_cin = w_a_in[L][WIDTH-1] ^ w_b_in[L][WIDTH-1] ^ w_s_nxt[L][WIDTH-1];
        w_ovf     = w_c_nxt[L] ^ w_msb_cin;
`ifdef CLA_PIPE_SAT_EN
        // positive overflow only happens with A non-negative, negative with A negative
        if (w_ovf) begin
            w_s_fin = w_a_in[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            w_s_fin = w_s_nxt[L];
        end
`else
        w_s_fin = w_s_nxt[L];
`endif
        w_zero = (w_s_fin == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_vld[k] <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_s[k]   <= '0;
                r_c[k]   <= 1'b0;
            end
            r_s_out <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else if (w_adv) begin
            r_vld[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            for (int k = 0; k < STAGES; k++) begin
                r_a[k] <= w_a_in[k];
                r_b[k] <= w_b_in[k];
                r_s[k] <= w_s_nxt[k];
                r_c[k] <= w_c_nxt[k];
            end
            r_s_out <= w_s_fin;
            r_cout  <= w_c_nxt[L];
            r_ovf   <= w_ovf;
            r_zero  <= w_zero;
        end
    end

    assign out_valid = r_vld[L];
    assign s         = r_s_out;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;
    assign zero      = r_zero;

endmodule
